// File: rtl/clkmul_pkg.sv
// rtl/clkmul_pkg.sv - shared state and error encodings for clock_multiplier_n
package clkmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_DIVIDE,
        ST_RUN
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_TOO_FAST = 2'd2;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per cycle
module seq_divider #(
    parameter int DVD_W = 24,
    parameter int DSR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DSR_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DSR_W:0]   remainder
);

    localparam int ITER_W = $clog2(DVD_W + 1);

    logic [DVD_W-1:0]  quo;
    logic [DSR_W:0]    rem;
    logic [DSR_W-1:0]  dsr;
    logic [ITER_W-1:0] iter;
    logic [DSR_W:0]    rem_shift;

    // The partial remainder is always below the divisor, so its low DSR_W bits suffice for the shift.
    assign rem_shift = {rem[DSR_W-1:0], quo[DVD_W-1]};
    assign quotient  = quo;
    assign remainder = rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            quo  <= '0;
            rem  <= '0;
            dsr  <= '0;
            iter <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo  <= dividend;
                rem  <= '0;
                dsr  <= divisor;
                iter <= ITER_W'(DVD_W);
                busy <= 1'b1;
            end else if (busy) begin
                if (rem_shift >= {1'b0, dsr}) begin
                    rem <= rem_shift - {1'b0, dsr};
                    quo <= {quo[DVD_W-2:0], 1'b1};
                end else begin
                    rem <= rem_shift;
                    quo <= {quo[DVD_W-2:0], 1'b0};
                end
                iter <= iter - ITER_W'(1);
                if (iter == ITER_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clock_multiplier_n.sv
// rtl/clock_multiplier_n.sv - measures a slow reference and emits a dithered mult-times square wave
module clock_multiplier_n
    import clkmul_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int MULT_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              enable,
    input  logic              ref_in,
    input  logic [MULT_W-1:0] mult,
    output logic              clk_out,
    output logic              locked,
    output logic [CNT_W-1:0]  period,
    output logic [1:0]        err
);

    localparam int AW = MULT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] ref_sync;
    logic                   ref_d;
    logic                   ref_edge;

    state_t            state;
    logic              acq_seen;
    logic [CNT_W-1:0]  count;
    logic [MULT_W-1:0] m_now, m_div, m_run;
    logic [CNT_W-1:0]  q_run, hcnt;
    logic [AW-1:0]     r_run, acc;
    logic [MULT_W:0]   hp_left;
    logic              burst_on;

    logic              div_start, div_busy, div_done;
    logic [CNT_W-1:0]  div_q;
    logic [AW-1:0]     div_r;

    logic              sat, fast, load_sel, ge;
    logic [AW-1:0]     twom_base, sum, next_acc;
    logic [CNT_W-1:0]  next_len;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            ref_sync <= '0;
            ref_d    <= 1'b0;
        end else begin
            ref_sync[0] <= ref_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ref_sync[i] <= ref_sync[i-1];
            end
            ref_d <= ref_sync[SYNC_STAGES-1];
        end
    end

    // One datapath picks the next half-period: on a burst load it starts from a cleared accumulator.
    always_comb begin
        m_now     = (mult == '0) ? MULT_W'(1) : mult;
        ref_edge  = ref_sync[SYNC_STAGES-1] & ~ref_d;
        sat       = (state != ST_IDLE) && (count == CNT_MAX) && !ref_edge;
        fast      = (ref_edge && (state == ST_DIVIDE || (state == ST_RUN && div_busy)))
                 || (state != ST_IDLE && div_done && div_q == '0);
        div_start = ref_edge && ((state == ST_ACQUIRE && acq_seen) || (state == ST_RUN && !div_busy));
        load_sel  = (state == ST_RUN) && ref_edge;
        twom_base = load_sel ? {1'b0, m_div, 1'b0} : {1'b0, m_run, 1'b0};
        sum       = (load_sel ? '0 : acc) + (load_sel ? div_r : r_run);
        ge        = (sum >= twom_base);
        next_acc  = ge ? sum - twom_base : sum;
        next_len  = (load_sel ? div_q : q_run) + CNT_W'(ge);
    end

    seq_divider #(
        .DVD_W (CNT_W),
        .DSR_W (MULT_W + 1)
    ) u_div (
        .clk       (clk_in),
        .rst       (rst),
        .start     (div_start),
        .dividend  (count),
        .divisor   ({m_now, 1'b0}),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= ST_IDLE;
            acq_seen <= 1'b0;
            count    <= '0;
            m_div    <= '0;
            m_run    <= '0;
            q_run    <= '0;
            r_run    <= '0;
            acc      <= '0;
            hcnt     <= '0;
            hp_left  <= '0;
            burst_on <= 1'b0;
            clk_out  <= 1'b0;
            locked   <= 1'b0;
            period   <= '0;
            err      <= ERR_NONE;
        end else if (!enable) begin
            state    <= ST_IDLE;
            acq_seen <= 1'b0;
            count    <= '0;
            burst_on <= 1'b0;
            clk_out  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            if (ref_edge) begin
                count <= CNT_W'(1);
            end else if (state != ST_IDLE && count != CNT_MAX) begin
                count <= count + CNT_W'(1);
            end

            if (sat || fast) begin
                err      <= fast ? ERR_TOO_FAST : ERR_OVERFLOW;
                state    <= ST_ACQUIRE;
                acq_seen <= 1'b0;
                locked   <= 1'b0;
                clk_out  <= 1'b0;
                burst_on <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_ACQUIRE;
                        clk_out <= 1'b0;
                    end
                    ST_ACQUIRE: begin
                        if (ref_edge) begin
                            if (!acq_seen) begin
                                acq_seen <= 1'b1;
                            end else begin
                                period <= count;
                                m_div  <= m_now;
                                state  <= ST_DIVIDE;
                            end
                        end
                    end
                    ST_DIVIDE: begin
                        if (div_done) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (ref_edge) begin
                            period   <= count;
                            m_div    <= m_now;
                            q_run    <= div_q;
                            r_run    <= div_r;
                            m_run    <= m_div;
                            acc      <= next_acc;
                            hcnt     <= next_len;
                            hp_left  <= {m_div, 1'b0};
                            clk_out  <= 1'b1;
                            burst_on <= 1'b1;
                            // The quotient only matches the ratio if m did not change since it was started.
                            locked   <= (m_div == m_now);
                            if (m_div == m_now) begin
                                err <= ERR_NONE;
                            end
                        end else if (burst_on) begin
                            if (hcnt == CNT_W'(1)) begin
                                if (hp_left == (MULT_W+1)'(1)) begin
                                    burst_on <= 1'b0;
                                    clk_out  <= 1'b0;
                                end else begin
                                    clk_out <= ~clk_out;
                                    hp_left <= hp_left - (MULT_W+1)'(1);
                                    hcnt    <= next_len;
                                    acc     <= next_acc;
                                end
                            end else begin
                                hcnt <= hcnt - CNT_W'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_multiplier_n.sv
// tb/tb_clock_multiplier_n.sv - randomized self-checking bench for clock_multiplier_n
module tb_clock_multiplier_n;

    localparam int CNT_W       = 12;
    localparam int MULT_W      = 4;
    localparam int SYNC_STAGES = 2;

    logic              clk_in;
    logic              rst;
    logic              enable;
    logic              ref_in;
    logic [MULT_W-1:0] mult;
    logic              clk_out;
    logic              locked;
    logic [CNT_W-1:0]  period;
    logic [1:0]        err;

    int n_checks = 0;
    int n_errors = 0;

    int ref_period = 1000;
    bit ref_run    = 1'b0;
    int ph         = 0;
    int n_edges    = 0;

    clock_multiplier_n #(
        .CNT_W       (CNT_W),
        .MULT_W      (MULT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .enable  (enable),
        .ref_in  (ref_in),
        .mult    (mult),
        .clk_out (clk_out),
        .locked  (locked),
        .period  (period),
        .err     (err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference: rising edge every ref_period cycles, roughly 50% duty.
    initial begin
        ref_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (ref_run) begin
                ph++;
                if (ph >= ref_period) ph = 0;
                if (ph == 0) n_edges++;
                ref_in = (ph < ref_period / 2);
            end else begin
                ph     = ref_period - 1;
                ref_in = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_eff(input int mu);
        return (mu == 0) ? 1 : mu;
    endfunction

    // Cumulative output time after k half-periods is floor(k*P/(2m)); each half is the difference.
    function automatic int exp_half(input int p, input int m, input int h);
        return ((h + 1) * p) / (2 * m) - (h * p) / (2 * m);
    endfunction

    task automatic wait_lock(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (locked) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic measure_burst(input int p, input int m, input string tag);
        int sum;
        int len;
        logic lvl;
        sum = 0;
        for (int h = 0; h < 2 * m; h++) begin
            lvl = ((h % 2) == 0);
            len = 0;
            while (clk_out === lvl && len < 5000) begin
                len++;
                @(negedge clk_in);
            end
            check($sformatf("%s_half%0d", tag, h), len, exp_half(p, m, h));
            sum += len;
        end
        check($sformatf("%s_sum", tag), sum, p);
    endtask

    task automatic start_case(input int mu, input int p);
        @(negedge clk_in);
        ref_run = 1'b0;
        rst     = 1'b1;
        @(negedge clk_in);
        check("rst_clk_out", clk_out, 0);
        check("rst_locked", locked, 0);
        check("rst_period", period, 0);
        check("rst_err", err, 0);
        repeat (3) @(negedge clk_in);
        mult       = MULT_W'(mu);
        ref_period = p;
        enable     = 1'b1;
        rst        = 1'b0;
        repeat (10) @(negedge clk_in);
        n_edges = 0;
        ref_run = 1'b1;
    endtask

    task automatic run_case(input int mu, input int p);
        bit ok;
        string tag;
        tag = $sformatf("m%0d_p%0d", mu, p);
        start_case(mu, p);
        wait_lock(4 * p + 200, ok);
        check({tag, "_lock_seen"}, ok, 1);
        if (ok) begin
            check({tag, "_lock_edge"}, n_edges, 3);
            check({tag, "_period"}, period, p);
            check({tag, "_err"}, err, 0);
            measure_burst(p, m_eff(mu), tag);
        end
    endtask

    initial begin
        bit ok;
        bit seen;
        int e0;
        int mu;
        int p;
        rst    = 1'b1;
        enable = 1'b0;
        mult   = '0;
        repeat (3) @(negedge clk_in);

        run_case(2, 1000);

        // Ratio change mid-run: unlock on the next edge, relock one edge later.
        mult = MULT_W'(3);
        e0   = n_edges;
        for (int i = 0; i < 1100 && n_edges == e0; i++) @(negedge clk_in);
        repeat (6) @(negedge clk_in);
        check("mchg_unlock", locked, 0);
        wait_lock(1100, ok);
        check("mchg_relock_seen", ok, 1);
        check("mchg_relock_edge", n_edges, e0 + 2);
        check("mchg_err", err, 0);
        measure_burst(1000, 3, "mchg");

        run_case(4, 1003);
        run_case(0, 500);
        repeat (4) begin
            mu = $urandom_range(1, 15);
            p  = $urandom_range(100, 1200);
            run_case(mu, p);
        end

        // Reference lost: counter saturates.
        ref_run = 1'b0;
        repeat ((1 << CNT_W) + 100) @(negedge clk_in);
        check("lost_err", err, 1);
        check("lost_locked", locked, 0);
        check("lost_clk_out", clk_out, 0);

        // Reference faster than the divider can keep up with.
        start_case(2, 10);
        seen = 1'b0;
        repeat (400) begin
            @(negedge clk_in);
            if (locked) seen = 1'b1;
        end
        check("fast_never_locked", seen, 0);
        check("fast_err", err, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
